// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - CDB requester/broadcast bundle shared by producers and the arbiter
interface cdb_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
);
    localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*TAG_W-1:0]  req_tag;
    logic [NREQ*DATA_W-1:0] req_value;
    logic [NREQ-1:0]        req_grant;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [DATA_W-1:0]      cdb_value;
    logic [SRC_W-1:0]       cdb_src;

    modport master (
        output req_valid, req_tag, req_value,
        input  req_grant, cdb_valid, cdb_tag, cdb_value, cdb_src
    );

    modport slave (
        input  req_valid, req_tag, req_value,
        output req_grant, cdb_valid, cdb_tag, cdb_value, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with registered broadcast
// Optional CDB_STALL_CNT_EN adds a saturating count of cycles where a valid requester lost arbitration.
module cdb_arbiter #(
    parameter int NREQ   = 3,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rdy,
    input  logic            clear,
    cdb_arbiter_if.slave    bus
`ifdef CDB_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
    logic [PTR_W-1:0]  cdb_src_q, cdb_src_d;

    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic              grant_en;

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_found && bus.req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    assign grant_en      = rst_n & rdy & ~clear & win_found;
    assign bus.req_grant = grant_en ? (NREQ'(1) << win_idx) : '0;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_value_d = cdb_value_q;
        cdb_src_d   = cdb_src_q;
        if (rdy) begin
            if (clear) begin
                cdb_valid_d = 1'b0;
            end else if (win_found) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = bus.req_tag[int'(win_idx)*TAG_W +: TAG_W];
                cdb_value_d = bus.req_value[int'(win_idx)*DATA_W +: DATA_W];
                cdb_src_d   = win_idx;
                rr_ptr_d    = (win_idx == PTR_W'(NREQ-1)) ? '0 : PTR_W'(win_idx + 1'b1);
            end else begin
                cdb_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            cdb_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_value = cdb_value_q;
    assign bus.cdb_src   = cdb_src_q;

`ifdef CDB_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // More than one valid requester in an arbitrating cycle means someone was denied.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (rdy && !clear && ($countones(bus.req_valid) > 1) && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter for the common data bus (CDB).
- Up to NREQ result producers compete for one broadcast slot per cycle: the reservation-station execute port, the store/load buffer load-return port and the ROB commit-forward port.
- The winner is granted combinationally, and its tag/value are registered onto the CDB one cycle later.
- The CDB feeds the RS, SLB and ROB tag-match/wakeup logic, so at most one wakeup event reaches the consumers per cycle.

Parameters:
- NREQ, 3, number of requesters (2..8).
- TAG_W, 5, ROB tag width (32-entry ROB).
- DATA_W, 32, result value width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- rdy  input  1  global ready; 0 = stall: no grants, all state held.
- clear  input  1  pipeline flush (mispredict), synchronous, qualified by rdy.
- req_valid  input  NREQ  per-requester request.
- req_tag  input  NREQ*TAG_W  packed per-requester ROB tags; requester i occupies bits [i*TAG_W +: TAG_W].
- req_value  input  NREQ*DATA_W  packed per-requester results.
- req_grant  output  NREQ  one-hot grant, combinational, same cycle as the request.
- cdb_valid  output  1  registered broadcast valid.
- cdb_tag  output  TAG_W  registered broadcast tag.
- cdb_value  output  DATA_W  registered broadcast value.
- cdb_src  output  clog2(NREQ)  index of the requester that produced the current broadcast.

Behaviour:
- Reset (rst_n=0, async):
  - cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0.
  - rr_ptr=0.
  - req_grant=0 while reset is asserted.
- Requester handshake:
  - A requester holds valid/tag/value stable until it sees req_grant[i]=1 at a clock edge.
  - A transfer occurs on any edge where req_valid[i]&req_grant[i]. The requester may drop or replace its request the next cycle.
- Arbitration (combinational):
  - If rdy=1 and clear=0, scan indices rr_ptr, rr_ptr+1, ... modulo NREQ. The first set req_valid bit wins and gets req_grant=1; all other grants are 0.
  - If rdy=0 or clear=1, req_grant=0.
  - req_grant is never set for a requester whose req_valid=0.
- Update on clk rising edge, in priority order:
  - rdy=0: hold everything, including cdb_valid. Consumers already qualify their own logic with rdy.
  - clear=1: cdb_valid<=0; rr_ptr unchanged; cdb_tag/value/src unchanged.
  - A grant to winner w: cdb_valid<=1, cdb_tag<=req_tag[w], cdb_value<=req_value[w], cdb_src<=w, and rr_ptr <= (w+1) mod NREQ.
  - No request: cdb_valid<=0; rr_ptr unchanged.
- Latency:
  - Request to grant: 0 cycles.
  - Grant to cdb_valid: 1 cycle.
  - Each cdb_valid pulse lasts exactly 1 cycle unless stalled by rdy=0.
- Throughput: one broadcast per cycle; back-to-back broadcasts are allowed.
- Fairness: a continuously asserted request is granted within NREQ cycles of rdy=1, clear=0 operation.
- Boundary conditions:
  - rr_ptr wraps from NREQ-1 to 0.
  - All NREQ requesting: grant order is i, i+1, ..., wrapping.
  - clear in the same cycle as a request: no grant, so the request is not consumed. The requester is itself flushed by clear.
  - rdy=0 with a pending cdb_valid=1: the broadcast is held and repeated once rdy returns. Consumers see it valid for one rdy=1 edge only.
  - rst_n asserted mid-broadcast: outputs clear immediately, without waiting for clk.
- Tags are not compared or filtered here. Duplicate tags are a producer error and are not detected.

Optional Feature:
- Macro: CDB_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt, width 32.
  - stall_cnt counts cycles with rdy=1, clear=0 in which popcount(req_valid) > 1, i.e. some valid requester was denied.
  - Saturates at 32'hFFFF_FFFF.
  - Reset to 0 by rst_n; not cleared by clear.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst_n=0 -> all outputs 0, req_grant=0. Release, req_valid=0 for 5 cycles -> cdb_valid stays 0.
- Single requester: req_valid=3'b010, tag=5'd7, value=32'hDEAD_BEEF -> req_grant=3'b010 same cycle. Next cycle cdb_valid=1, cdb_tag=7, cdb_value=DEADBEEF, cdb_src=1, rr_ptr=2.
- Full contention: req_valid=3'b111 held 6 cycles from rr_ptr=0 -> grants 001,010,100,001,010,100. cdb_src sequence 0,1,2,0,1,2. With CDB_STALL_CNT_EN, stall_cnt=6.
- Flush collision: req_valid=3'b001 with clear=1 -> req_grant=0. Next cycle cdb_valid=0 and rr_ptr unchanged. With clear=0 the following cycle, the grant goes to requester 0.
- Stall hold: broadcast tag 3 pending (cdb_valid=1), rdy=0 for 3 cycles with req_valid=3'b100 -> req_grant=0, cdb_valid/tag held at 1/3. rdy=1 -> requester 2 is granted.
- Async reset mid-operation: during full contention, drop rst_n between clock edges -> cdb_valid=0 and rr_ptr=0 immediately. After release, the first grant goes to requester 0.
